// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the sample loop source.
// Build option SAMPLE_LOOP_WRAP_EN (used by the top) selects looping playback.
package audio_pkg;

   localparam int SAMPLE_W   = 12;
   localparam int DEF_ADDR_W = 12;

   localparam logic [2:0] IDLE_ENC      = 3'd0;
   localparam logic [2:0] RECORD_ENC    = 3'd1;
   localparam logic [2:0] PLAY_ARM_ENC  = 3'd2;
   localparam logic [2:0] PLAY_READ_ENC = 3'd3;
   localparam logic [2:0] PLAY_WAIT_ENC = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = IDLE_ENC,
      S_RECORD    = RECORD_ENC,
      S_PLAY_ARM  = PLAY_ARM_ENC,
      S_PLAY_READ = PLAY_READ_ENC,
      S_PLAY_WAIT = PLAY_WAIT_ENC
   } state_e;

endpackage

// File: rtl/sample_ram.sv
// Single-port synchronous sample buffer with one-cycle registered read.
// Contents are never reset; only the control logic around it is.
module sample_ram
   import audio_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = SAMPLE_W
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

   // Write port plus registered read of the same address.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      dout <= mem_q[addr];
   end

endmodule

// File: rtl/sample_loop_source.sv
// Records codec samples and replays them to the effects chain with a start/done handshake.
// Define SAMPLE_LOOP_WRAP_EN to loop the buffer while playback stays high.
module sample_loop_source
   import audio_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = SAMPLE_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              record,
   input  logic              playback,
   input  logic              ready_in,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              chain_done,
   output logic              start_out,
   output logic [DATA_W-1:0] sample_out,
   output logic              busy,
   output logic [ADDR_W:0]   rec_length,
   output logic              full,
   output logic              underrun
);

   localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

   state_e            state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   rec_length_q, rec_length_d;
   logic              full_q, full_d;
   logic              underrun_q, underrun_d;
   logic              start_out_q, start_out_d;
   logic [DATA_W-1:0] sample_out_q, sample_out_d;
   logic              busy_q, busy_d;
   logic              rec_block_q, rec_block_d;
   logic              play_ok;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dout;
   logic [ADDR_W:0]   wr_next;
   logic [ADDR_W:0]   rd_next;

   assign wr_next = wr_ptr_q + PTR_ONE;
   assign rd_next = rd_ptr_q + PTR_ONE;

`ifdef SAMPLE_LOOP_WRAP_EN
   assign play_ok = 1'b1;
`else
   // Set at end of a pass; playback must drop before another pass may start.
   logic need_rise_q, need_rise_d;
   assign play_ok = ~need_rise_q;
`endif

   sample_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .din   (sample_in),
      .dout  (ram_dout)
   );

   // Next-state and next-output computation for the record/playback sequencer.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rec_length_d = rec_length_q;
      full_d       = full_q;
      underrun_d   = underrun_q;
      start_out_d  = 1'b0;
      sample_out_d = sample_out_q;
      busy_d       = busy_q;
      rec_block_d  = rec_block_q & record;
`ifndef SAMPLE_LOOP_WRAP_EN
      need_rise_d  = need_rise_q & playback;
`endif
      ram_we       = 1'b0;
      ram_addr     = rd_ptr_q[ADDR_W-1:0];

      case (state_q)
         S_IDLE: begin
            if (record && !rec_block_q) begin
               state_d      = S_RECORD;
               wr_ptr_d     = PTR_ZERO;
               rec_length_d = PTR_ZERO;
               full_d       = 1'b0;
            end else if (playback && (rec_length_q != PTR_ZERO) && play_ok) begin
               state_d    = S_PLAY_ARM;
               rd_ptr_d   = PTR_ZERO;
               underrun_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RECORD: begin
            if (!record) begin
               state_d = S_IDLE;
            end else if (ready_in) begin
               ram_we       = 1'b1;
               ram_addr     = wr_ptr_q[ADDR_W-1:0];
               wr_ptr_d     = wr_next;
               rec_length_d = wr_next;
               // A full buffer ends the take; record must drop before a new one.
               if (wr_next == PTR_FULL) begin
                  full_d      = 1'b1;
                  rec_block_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_RECORD;
               end
            end else begin
               state_d = S_RECORD;
            end
         end

         S_PLAY_ARM: begin
            if (!playback) begin
               state_d = S_IDLE;
            end else if (ready_in) begin
               state_d = S_PLAY_READ;
            end else begin
               state_d = S_PLAY_ARM;
            end
         end

         S_PLAY_READ: begin
            sample_out_d = ram_dout;
            start_out_d  = 1'b1;
            busy_d       = 1'b1;
            state_d      = S_PLAY_WAIT;
         end

         S_PLAY_WAIT: begin
            if (ready_in) begin
               underrun_d = 1'b1;
            end else begin
               underrun_d = underrun_q;
            end
            if (chain_done) begin
               busy_d   = 1'b0;
               rd_ptr_d = rd_next;
               if (rd_next == rec_length_q) begin
`ifdef SAMPLE_LOOP_WRAP_EN
                  rd_ptr_d = PTR_ZERO;
                  state_d  = playback ? S_PLAY_ARM : S_IDLE;
`else
                  state_d     = S_IDLE;
                  need_rise_d = 1'b1;
`endif
               end else begin
                  state_d = playback ? S_PLAY_ARM : S_IDLE;
               end
            end else begin
               state_d = S_PLAY_WAIT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= PTR_ZERO;
         rd_ptr_q     <= PTR_ZERO;
         rec_length_q <= PTR_ZERO;
         full_q       <= 1'b0;
         underrun_q   <= 1'b0;
         start_out_q  <= 1'b0;
         sample_out_q <= {DATA_W{1'b0}};
         busy_q       <= 1'b0;
         rec_block_q  <= 1'b0;
`ifndef SAMPLE_LOOP_WRAP_EN
         need_rise_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rec_length_q <= rec_length_d;
         full_q       <= full_d;
         underrun_q   <= underrun_d;
         start_out_q  <= start_out_d;
         sample_out_q <= sample_out_d;
         busy_q       <= busy_d;
         rec_block_q  <= rec_block_d;
`ifndef SAMPLE_LOOP_WRAP_EN
         need_rise_q  <= need_rise_d;
`endif
      end
   end

   assign start_out  = start_out_q;
   assign sample_out = sample_out_q;
   assign busy       = busy_q;
   assign rec_length = rec_length_q;
   assign full       = full_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_sample_loop_source.sv
// Directed/randomized bench for sample_loop_source with a small 8-entry buffer.
// Expectations come from a queue model of the recorded take.
module tb_sample_loop_source;

   localparam int AW = 3;
   localparam int DW = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          record = 1'b0;
   logic          playback = 1'b0;
   logic          ready_in = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic          chain_done = 1'b0;
   logic          start_out;
   logic [DW-1:0] sample_out;
   logic          busy;
   logic [AW:0]   rec_length;
   logic          full;
   logic          underrun;

   int vectors = 0;
   int miscompares = 0;
   logic [DW-1:0] rec_q[$];
   logic [DW-1:0] fixed_tbl [5] = '{12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h123};

   sample_loop_source #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .record     (record),
      .playback   (playback),
      .ready_in   (ready_in),
      .sample_in  (sample_in),
      .chain_done (chain_done),
      .start_out  (start_out),
      .sample_out (sample_out),
      .busy       (busy),
      .rec_length (rec_length),
      .full       (full),
      .underrun   (underrun)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) tick();
   endtask

   // Strobe in PLAY_ARM and expect start_out with exp exactly two cycles later.
   task automatic issue(input logic [DW-1:0] exp);
      ready_in  = 1'b1;
      sample_in = DW'($urandom);
      tick();
      ready_in = 1'b0;
      check("start_early", {31'd0, start_out}, 32'd0);
      tick();
      check("start_pulse", {31'd0, start_out}, 32'd1);
      check("sample_out", {20'd0, sample_out}, {20'd0, exp});
      check("busy_set", {31'd0, busy}, 32'd1);
   endtask

   // Return chain_done dly cycles after the start pulse.
   task automatic finish(input int dly);
      repeat (dly - 1) begin
         tick();
         check("busy_hold", {31'd0, busy}, 32'd1);
         check("start_single", {31'd0, start_out}, 32'd0);
      end
      chain_done = 1'b1;
      tick();
      chain_done = 1'b0;
      check("busy_clear", {31'd0, busy}, 32'd0);
      check("start_after_done", {31'd0, start_out}, 32'd0);
   endtask

   // Strobe while no pass should be running and expect no start pulse.
   task automatic no_issue(input string tag);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      repeat (3) begin
         tick();
         check(tag, {31'd0, start_out}, 32'd0);
      end
   endtask

   initial begin
      int k;
      logic [DW-1:0] v;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      check("rst_start", {31'd0, start_out}, 32'd0);
      check("rst_sample", {20'd0, sample_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_len", {28'd0, rec_length}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);

      // Record the fixed five-sample take
      record = 1'b1;
      tick();
      rec_q.delete();
      for (int i = 0; i < 5; i++) begin
         gap();
         ready_in  = 1'b1;
         sample_in = fixed_tbl[i];
         tick();
         ready_in = 1'b0;
         rec_q.push_back(fixed_tbl[i]);
         check("rec_len_step", {28'd0, rec_length}, 32'(rec_q.size()));
      end
      record    = 1'b0;
      ready_in  = 1'b1;
      sample_in = 12'h555;
      tick();
      ready_in = 1'b0;
      tick();
      check("rec_len5", {28'd0, rec_length}, 32'd5);
      check("rec_full0", {31'd0, full}, 32'd0);

      // Full playback pass, done returned three cycles after each start
      playback = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         gap();
         issue(rec_q[i]);
         finish(3);
      end
      check("pass_underrun", {31'd0, underrun}, 32'd0);
`ifdef SAMPLE_LOOP_WRAP_EN
      gap();
      issue(rec_q[0]);
      playback = 1'b0;
      finish(3);
      no_issue("wrap_stop");
`else
      no_issue("no_restart");
      playback = 1'b0;
      tick();
`endif

      // Withheld done: strobes while busy are lost and flagged
      playback = 1'b1;
      tick();
      issue(rec_q[0]);
      for (int j = 0; j < 2; j++) begin
         tick();
         ready_in = 1'b1;
         tick();
         ready_in = 1'b0;
         check("underrun_set", {31'd0, underrun}, 32'd1);
         check("start_none", {31'd0, start_out}, 32'd0);
         check("busy_wait", {31'd0, busy}, 32'd1);
         check("sample_stable", {20'd0, sample_out}, {20'd0, rec_q[0]});
      end
      ready_in   = 1'b1;
      chain_done = 1'b1;
      tick();
      ready_in   = 1'b0;
      chain_done = 1'b0;
      check("done_ready_busy", {31'd0, busy}, 32'd0);
      repeat (3) begin
         tick();
         check("no_issue_after_dr", {31'd0, start_out}, 32'd0);
      end
      issue(rec_q[1]);
      finish(2);
      check("underrun_sticky", {31'd0, underrun}, 32'd1);
      playback = 1'b0;
      tick();

      // New pass clears underrun; random done latencies
      playback = 1'b1;
      tick();
      check("underrun_clr", {31'd0, underrun}, 32'd0);
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
         gap();
         issue(rec_q[i]);
         finish($urandom_range(1, 6));
      end
      playback = 1'b0;
      tick();

      // Reset while waiting for done
      playback = 1'b1;
      tick();
      issue(rec_q[0]);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_start", {31'd0, start_out}, 32'd0);
      check("mid_rst_sample", {20'd0, sample_out}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_len", {28'd0, rec_length}, 32'd0);
      check("mid_rst_full", {31'd0, full}, 32'd0);
      check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
      chain_done = 1'b1;
      tick();
      chain_done = 1'b0;
      check("late_done_busy", {31'd0, busy}, 32'd0);
      check("late_done_start", {31'd0, start_out}, 32'd0);
      no_issue("empty_play");
      no_issue("empty_play2");
      playback = 1'b0;
      tick();

      // Overfill the buffer: ten strobes into eight entries
      rec_q.delete();
      record = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         gap();
         v         = DW'($urandom);
         ready_in  = 1'b1;
         sample_in = v;
         tick();
         ready_in = 1'b0;
         if (rec_q.size() < 8) rec_q.push_back(v);
         check("fill_len", {28'd0, rec_length}, 32'(rec_q.size()));
         check("fill_full", {31'd0, full}, 32'((i >= 7) ? 1 : 0));
      end
      record = 1'b0;
      tick();
      check("full_len8", {28'd0, rec_length}, 32'd8);

      // Record wins over playback in IDLE; new take then replays
      record   = 1'b1;
      playback = 1'b1;
      tick();
      check("prio_len", {28'd0, rec_length}, 32'd0);
      check("prio_full", {31'd0, full}, 32'd0);
      rec_q.delete();
      for (int i = 0; i < 3; i++) begin
         v         = DW'($urandom);
         ready_in  = 1'b1;
         sample_in = v;
         tick();
         ready_in = 1'b0;
         rec_q.push_back(v);
      end
      check("prio_len3", {28'd0, rec_length}, 32'd3);
      record = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         gap();
         issue(rec_q[i]);
         finish($urandom_range(1, 4));
      end
      playback = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
